// File: rtl/load_use_interlock.sv
// Load-use interlock: stall side of the EX/WB forwarding path.
// Detects a load in EX whose rd is read by the instruction in ID, holds
// IF/ID and bubbles EX until the load data returns, then steers the captured
// memory data into the dependent operand(s) for one cycle.
// Optional feature: define INTERLOCK_PERF_CNT_EN to build the stall-cycle
// performance counter; otherwise stall_cycles is tied to zero.
module load_use_interlock #(
  parameter int CPU_INST_BITS = 32,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CPU_INST_BITS-1:0] inst_ID,
  input  logic                     id_valid,
  input  logic [CPU_INST_BITS-1:0] inst_EX,
  input  logic                     ex_valid,
  input  logic                     dmem_resp_valid,
  input  logic                     flush_id,
  output logic                     stall_if_id,
  output logic                     bubble_ex,
  output logic                     fwd_A_mem,
  output logic                     fwd_B_mem,
  output logic                     err_timeout,
  output logic [31:0]              stall_cycles
);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;
  localparam logic [2:0] FNC_RW        = 3'b001;

  // Timeout threshold in the width of the wait counter (legal range 1..255)
  localparam logic [7:0] TIMEOUT_CNT   = 8'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FWD  = 2'd2
  } state_t;

  state_t     state_reg;
  logic       hit_a_reg;
  logic       hit_b_reg;
  logic       fwd_a_reg;
  logic       fwd_b_reg;
  logic       err_reg;
  logic [7:0] wait_cnt_reg;
  logic [7:0] wait_cnt_next;

  // Instruction fields
  logic [6:0] opc_id;
  logic [6:0] opc_ex;
  logic [2:0] f3_id;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic [4:0] rd_ex;

  assign opc_id = inst_ID[6:0];
  assign f3_id  = inst_ID[14:12];
  assign rs1_id = inst_ID[19:15];
  assign rs2_id = inst_ID[24:20];
  assign opc_ex = inst_EX[6:0];
  assign rd_ex  = inst_EX[11:7];

  // Bits of the instructions the interlock never looks at
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_ID[CPU_INST_BITS-1:25], inst_ID[11:7],
                              inst_EX[CPU_INST_BITS-1:12]};

  logic use_rs1;
  logic use_rs2;

  // Which source registers the instruction in ID actually reads
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc_id)
      OPC_ARI_RTYPE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_ARI_ITYPE: use_rs1 = 1'b1;
      OPC_LOAD:      use_rs1 = 1'b1;
      OPC_STORE:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_BRANCH:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_JALR:      use_rs1 = 1'b1;
      OPC_CSR:       use_rs1 = (f3_id == FNC_RW);
      default:       begin use_rs1 = 1'b0; use_rs2 = 1'b0; end
    endcase
  end

  logic hit_a;
  logic hit_b;
  logic hit;

  // x0 never carries a dependency, so a load to rd=0 cannot hazard
  assign hit_a = use_rs1 & (rs1_id == rd_ex);
  assign hit_b = use_rs2 & (rs2_id == rd_ex);
  assign hit   = ex_valid & id_valid & ~flush_id & (opc_ex == OPC_LOAD)
               & (rd_ex != 5'd0) & (hit_a | hit_b);

  // Saturating increment so a very long wait never wraps back to zero
  assign wait_cnt_next = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg : wait_cnt_reg + 8'd1;

  logic stall_comb;

  // Stall is combinational: a fresh hit stalls in the same cycle, and while
  // waiting the hold drops in the very cycle the load data arrives
  always_comb begin
    stall_comb = 1'b0;
    case (state_reg)
      ST_WAIT: stall_comb = ~dmem_resp_valid;
      default: stall_comb = hit;
    endcase
  end

  assign stall_if_id = stall_comb;
  assign bubble_ex   = stall_comb;
  assign fwd_A_mem   = fwd_a_reg;
  assign fwd_B_mem   = fwd_b_reg;
  assign err_timeout = err_reg;

  // Interlock FSM; IDLE, FWD and any illegal encoding all evaluate a new hit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      hit_a_reg    <= 1'b0;
      hit_b_reg    <= 1'b0;
      fwd_a_reg    <= 1'b0;
      fwd_b_reg    <= 1'b0;
      err_reg      <= 1'b0;
      wait_cnt_reg <= 8'd0;
    end else begin
      fwd_a_reg <= 1'b0;
      fwd_b_reg <= 1'b0;
      case (state_reg)
        ST_WAIT: begin
          wait_cnt_reg <= wait_cnt_next;
          if (flush_id) begin
            // Dependent was killed: drop the pending forward
            state_reg <= ST_IDLE;
          end else if (dmem_resp_valid) begin
            state_reg <= ST_FWD;
            fwd_a_reg <= hit_a_reg;
            fwd_b_reg <= hit_b_reg;
          end else if (wait_cnt_next >= TIMEOUT_CNT) begin
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          if (hit) begin
            state_reg    <= ST_WAIT;
            hit_a_reg    <= hit_a;
            hit_b_reg    <= hit_b;
            wait_cnt_reg <= 8'd0;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef INTERLOCK_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;

  // Free-running count of stalled cycles; wraps naturally, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg <= 32'd0;
    end else if (stall_comb) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_load_use_interlock.sv
// Self-checking bench for load_use_interlock: a decode table applied from
// IDLE, plus hand-written multi-cycle sequences for delayed responses,
// flushes, back-to-back loads, timeout and mid-stall reset.
module tb_load_use_interlock;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_ID = 32'd0;
  logic        id_valid = 1'b0;
  logic [31:0] inst_EX = 32'd0;
  logic        ex_valid = 1'b0;
  logic        dmem_resp_valid = 1'b0;
  logic        flush_id = 1'b0;
  logic        stall_if_id;
  logic        bubble_ex;
  logic        fwd_A_mem;
  logic        fwd_B_mem;
  logic        err_timeout;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_use_interlock #(.CPU_INST_BITS(32), .STALL_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_ID(inst_ID), .id_valid(id_valid),
    .inst_EX(inst_EX), .ex_valid(ex_valid),
    .dmem_resp_valid(dmem_resp_valid), .flush_id(flush_id),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
    .fwd_A_mem(fwd_A_mem), .fwd_B_mem(fwd_B_mem),
    .err_timeout(err_timeout), .stall_cycles(stall_cycles)
  );

  // Instruction encoders (rs2 field of I-type carries imm[4:0])
  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, OPC_RTYPE};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] imm5);
    return {7'd0, imm5, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, OPC_STORE};
  endfunction
  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, OPC_BRANCH};
  endfunction
  // Opcodes with no source use; register fields deliberately set to x5
  function automatic logic [31:0] enc_u(input logic [6:0] opc, input logic [4:0] rd);
    return {7'd0, 5'd5, 5'd5, 3'd0, rd, opc};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return enc_i(OPC_LOAD, rd, rs1, 3'b010, 5'd0);
  endfunction

  typedef struct packed {
    logic s;
    logic a;
    logic b;
    logic e;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, queue the expectation, then
  // compare the settled outputs before the next rising edge
  task automatic step(input string nm, input logic [31:0] id, input logic idv,
                      input logic [31:0] ex, input logic exv, input logic resp, input logic fl,
                      input logic es, input logic ea, input logic eb, input logic ee);
    exp_t e;
    @(negedge clk);
    inst_ID = id; id_valid = idv; inst_EX = ex; ex_valid = exv;
    dmem_resp_valid = resp; flush_id = fl;
    sb.push_back('{s: es, a: ea, b: eb, e: ee});
    #2;
    e = sb.pop_front();
    $display("txn %s: stall=%b bubble=%b fa=%b fb=%b err=%b cnt=%0d",
             nm, stall_if_id, bubble_ex, fwd_A_mem, fwd_B_mem, err_timeout, stall_cycles);
    chk({nm, ".stall"},  {31'd0, stall_if_id}, {31'd0, e.s});
    chk({nm, ".bubble"}, {31'd0, bubble_ex},   {31'd0, e.s});
    chk({nm, ".fwdA"},   {31'd0, fwd_A_mem},   {31'd0, e.a});
    chk({nm, ".fwdB"},   {31'd0, fwd_B_mem},   {31'd0, e.b});
    chk({nm, ".err"},    {31'd0, err_timeout}, {31'd0, e.e});
  endtask

  task automatic idle(input string nm, input logic ea, input logic eb, input logic ee);
    step(nm, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, ee);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1; id_valid = 1'b0; ex_valid = 1'b0; dmem_resp_valid = 1'b0; flush_id = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] id;
    logic        idv;
    logic [31:0] ex;
    logic        exv;
    logic        fl;
    logic        es;
    logic        ea;
    logic        eb;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  logic [31:0] lw5;
  logic [31:0] add6;
  logic [31:0] exp_perf;

  initial begin
    lw5  = enc_lw(5'd5, 5'd1);
    add6 = enc_r(5'd6, 5'd5, 5'd7);
    vecs[0]  = '{add6,                                   1, lw5, 1, 0, 1, 1, 0};
    vecs[1]  = '{enc_r(5'd6, 5'd7, 5'd5),                1, lw5, 1, 0, 1, 0, 1};
    vecs[2]  = '{enc_s(5'd5, 5'd5),                      1, lw5, 1, 0, 1, 1, 1};
    vecs[3]  = '{enc_b(5'd5, 5'd6),                      1, lw5, 1, 0, 1, 1, 0};
    vecs[4]  = '{enc_i(OPC_ITYPE, 5'd6, 5'd9, 3'd0, 5'd5), 1, lw5, 1, 0, 0, 0, 0};
    vecs[5]  = '{enc_u(OPC_LUI, 5'd5),                   1, lw5, 1, 0, 0, 0, 0};
    vecs[6]  = '{enc_u(OPC_JAL, 5'd5),                   1, lw5, 1, 0, 0, 0, 0};
    vecs[7]  = '{enc_i(OPC_CSR, 5'd6, 5'd5, 3'b001, 5'd0), 1, lw5, 1, 0, 1, 1, 0};
    vecs[8]  = '{enc_i(OPC_CSR, 5'd6, 5'd5, 3'b101, 5'd5), 1, lw5, 1, 0, 0, 0, 0};
    vecs[9]  = '{enc_r(5'd6, 5'd0, 5'd0),                1, enc_lw(5'd0, 5'd1), 1, 0, 0, 0, 0};
    vecs[10] = '{add6,                                   0, lw5, 1, 0, 0, 0, 0};
    vecs[11] = '{add6,                                   1, lw5, 0, 0, 0, 0, 0};
    vecs[12] = '{add6,                                   1, lw5, 1, 1, 0, 0, 0};
    vecs[13] = '{add6,                                   1, enc_r(5'd5, 5'd1, 5'd2), 1, 0, 0, 0, 0};
    vecs[14] = '{enc_i(OPC_JALR, 5'd1, 5'd5, 3'd0, 5'd0), 1, lw5, 1, 0, 1, 1, 0};
    vecs[15] = '{enc_lw(5'd6, 5'd5),                     1, lw5, 1, 0, 1, 1, 0};
    vecs[16] = '{enc_u(OPC_AUIPC, 5'd5),                 1, lw5, 1, 0, 0, 0, 0};
    vecs[17] = '{enc_u(7'b1111111, 5'd5),                1, lw5, 1, 0, 0, 0, 0};
    vecs[18] = '{enc_i(OPC_ITYPE, 5'd6, 5'd5, 3'd0, 5'd0), 1, lw5, 1, 0, 1, 1, 0};
    vecs[19] = '{enc_s(5'd7, 5'd5),                      1, lw5, 1, 0, 1, 0, 1};

    // Reset state
    reset_pulse();
    idle("reset", 0, 0, 0);
    chk("reset.stall_cycles", stall_cycles, 32'd0);

    // Decode table: hit from IDLE, 1-cycle response, single forward pulse
    for (int i = 0; i < NV; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      reset_pulse();
      step({nm, ".hit"}, vecs[i].id, vecs[i].idv, vecs[i].ex, vecs[i].exv, 1'b0, vecs[i].fl,
           vecs[i].es, 0, 0, 0);
      if (vecs[i].es) begin
        step({nm, ".resp"}, vecs[i].id, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        idle({nm, ".fwd"}, vecs[i].ea, vecs[i].eb, 0);
      end
      idle({nm, ".after"}, 0, 0, 0);
    end

    // lw x5 / sw x5,0(x5), response three cycles late
    reset_pulse();
    step("s2.hit", enc_s(5'd5, 5'd5), 1, lw5, 1, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      step($sformatf("s2.wait%0d", k), enc_s(5'd5, 5'd5), 1, 32'd0, 0, 0, 0, 1, 0, 0, 0);
    step("s2.resp", enc_s(5'd5, 5'd5), 1, 32'd0, 0, 1, 0, 0, 0, 0, 0);
    step("s2.fwd", enc_r(5'd1, 5'd2, 5'd3), 1, enc_s(5'd5, 5'd5), 1, 0, 0, 0, 1, 1, 0);
    idle("s2.after", 0, 0, 0);
`ifdef INTERLOCK_PERF_CNT_EN
    exp_perf = 32'd4;
`else
    exp_perf = 32'd0;
`endif
    chk("s2.stall_cycles", stall_cycles, exp_perf);

    // Flush in the second WAIT cycle drops the forward
    reset_pulse();
    step("s4.hit", enc_b(5'd5, 5'd6), 1, lw5, 1, 0, 0, 1, 0, 0, 0);
    step("s4.wait", enc_b(5'd5, 5'd6), 1, 32'd0, 0, 0, 0, 1, 0, 0, 0);
    step("s4.flush", enc_b(5'd5, 5'd6), 1, 32'd0, 0, 0, 1, 1, 0, 0, 0);
    idle("s4.idle0", 0, 0, 0);
    idle("s4.idle1", 0, 0, 0);

    // Flush wins over a same-cycle response
    step("s4b.hit", add6, 1, lw5, 1, 0, 0, 1, 0, 0, 0);
    step("s4b.flushresp", add6, 1, 32'd0, 0, 1, 1, 0, 0, 0, 0);
    idle("s4b.nofwd", 0, 0, 0);

    // Back-to-back: lw x5 / lw x6,0(x5) / add x7,x6,x0
    step("bb.hit1", enc_lw(5'd6, 5'd5), 1, lw5, 1, 0, 0, 1, 0, 0, 0);
    step("bb.resp1", enc_lw(5'd6, 5'd5), 1, 32'd0, 0, 1, 0, 0, 0, 0, 0);
    step("bb.fwd_hit2", enc_r(5'd7, 5'd6, 5'd0), 1, enc_lw(5'd6, 5'd5), 1, 0, 0, 1, 1, 0, 0);
    step("bb.resp2", enc_r(5'd7, 5'd6, 5'd0), 1, 32'd0, 0, 1, 0, 0, 0, 0, 0);
    step("bb.fwd2", 32'd0, 0, enc_r(5'd7, 5'd6, 5'd0), 1, 0, 0, 0, 1, 0, 0);
    idle("bb.after", 0, 0, 0);

    // Timeout after four WAIT cycles, sticky until reset
    reset_pulse();
    step("to.hit", add6, 1, lw5, 1, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      step($sformatf("to.wait%0d", k), add6, 1, 32'd0, 0, 0, 0, 1, 0, 0, 0);
    idle("to.err0", 0, 0, 1);
    idle("to.err1", 0, 0, 1);
    step("to.rehit", add6, 1, lw5, 1, 0, 0, 1, 0, 0, 1);
    step("to.rewait", add6, 1, 32'd0, 0, 0, 0, 1, 0, 0, 1);

    // Reset mid-WAIT clears everything
    reset_pulse();
    idle("rst.clear", 0, 0, 0);
    chk("rst.stall_cycles", stall_cycles, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
